seg7_scan_driver: RTL and testbench

//  Multiplexed driver for the 4-digit 7-segment display. Consumes the digit values produced by the

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_decoder.sv | 12 +
 rtl/seg7_scan_driver.sv | 139 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, glyph table and timing helper for the 7-segment scan driver.
package seg7_pkg;

    // Two phases per digit slot: dead-time blank, then drive.
    typedef enum logic {
        BLANK,
        DRIVE
    } scanState_t;

    // Active-high glyphs, bit0 = a .. bit6 = g; 10..15 render as A b C d E F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Clock cycles per digit slot.
    function automatic int unsigned slot_cycles(input int unsigned clkHz,
                                                input int unsigned frameHz,
                                                input int unsigned digits);
        return clkHz / (frameHz * digits);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit value to active-high 7-segment glyph, with a force-blank input.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] valueIn,
    input  logic       blankIn,
    output logic [6:0] glyphOut
);

    assign glyphOut = blankIn ? 7'h00 : GLYPHS[valueIn];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with shadow register, dead-time blanking
// and leading-zero suppression. Every pin is driven straight from a register.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned FRAME_HZ    = 250,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DEAD_CYCLES = 64,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          DIG_ACT_LOW = 1'b1
) (
    input  logic                  clkIn,
    input  logic                  resetIn,
    input  logic [4*DIGITS-1:0]   digitsIn,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic                  updateIn,
    input  logic                  blankLzIn,
    output logic [6:0]            segOut,
    output logic                  dpOut,
    output logic [DIGITS-1:0]     anodeOut,
    output logic                  frameOut
);

    localparam int unsigned SLOT  = slot_cycles(CLK_HZ, FRAME_HZ, DIGITS);
    localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Inactive levels as seen on the pins.
    localparam logic [6:0]        SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACT_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    if (SLOT <= DEAD_CYCLES || DEAD_CYCLES == 0) begin : gBadParams
        $error("seg7_scan_driver: DEAD_CYCLES must lie in 1..SLOT-1");
    end

    logic [4*DIGITS-1:0] shadowDigits;
    logic [DIGITS-1:0]   shadowDp;
    scanState_t          state;
    logic [CNT_W-1:0]    slotCnt;
    logic [IDX_W-1:0]    digitIdx;

    logic [DIGITS-1:0]   blankVec;
    logic [DIGITS-1:0]   curOneHot;
    logic [3:0]          curValue;
    logic                curDp;
    logic                curBlank;
    logic [6:0]          curGlyph;

    // Shadow register: captures the counter values only on the update strobe.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            shadowDigits <= '0;
            shadowDp     <= '0;
        end else if (updateIn) begin
            shadowDigits <= digitsIn;
            shadowDp     <= dpIn;
        end
    end

    // Leading-zero mask: digit k blanks when it and every more significant digit are zero.
    always_comb begin
        logic allZero;
        blankVec = '0;
        allZero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            allZero     = allZero && (shadowDigits[4*k +: 4] == 4'd0);
            blankVec[k] = blankLzIn && allZero;
        end
    end

    // Select the shadow value, dp and enable for the digit currently being scanned.
    always_comb begin
        curValue  = 4'd0;
        curDp     = 1'b0;
        curBlank  = 1'b0;
        curOneHot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digitIdx == IDX_W'(k)) begin
                curValue     = shadowDigits[4*k +: 4];
                curDp        = shadowDp[k];
                curBlank     = blankVec[k];
                curOneHot[k] = 1'b1;
            end
        end
    end

    seg7_decoder uDecoder (
        .valueIn  (curValue),
        .blankIn  (curBlank),
        .glyphOut (curGlyph)
    );

    // Scan FSM with registered pin outputs; segments are frozen on DRIVE entry.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state    <= BLANK;
            slotCnt  <= '0;
            digitIdx <= '0;
            segOut   <= SEG_OFF;
            dpOut    <= DP_OFF;
            anodeOut <= DIG_OFF;
            frameOut <= 1'b0;
        end else begin
            frameOut <= 1'b0;
            unique case (state)
                BLANK: begin
                    slotCnt <= slotCnt + 1'b1;
                    if (slotCnt == CNT_W'(DEAD_CYCLES - 1)) begin
                        state    <= DRIVE;
                        segOut   <= curGlyph ^ {7{SEG_ACT_LOW}};
                        dpOut    <= curDp ^ SEG_ACT_LOW;
                        anodeOut <= curOneHot ^ {DIGITS{DIG_ACT_LOW}};
                    end
                end
                DRIVE: begin
                    if (slotCnt == CNT_W'(SLOT - 1)) begin
                        slotCnt  <= '0;
                        state    <= BLANK;
                        segOut   <= SEG_OFF;
                        dpOut    <= DP_OFF;
                        anodeOut <= DIG_OFF;
                        if (digitIdx == IDX_W'(DIGITS - 1)) begin
                            digitIdx <= '0;
                            frameOut <= 1'b1;
                        end else begin
                            digitIdx <= digitIdx + 1'b1;
                        end
                    end else begin
                        slotCnt <= slotCnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: randomized and directed stimulus against a
// slot/frame-position reference model (SLOT=20, DEAD=2, 4 digits, active-low outputs).
module tb_seg7_scan_driver;

    localparam int SLOT  = 20;
    localparam int DEAD  = 2;
    localparam int FRAME = 80;
    localparam logic [12:0] RESET_OUT = {4'b1111, 7'h7F, 1'b1, 1'b0};

    logic        clkIn     = 1'b0;
    logic        resetIn   = 1'b0;
    logic [15:0] digitsIn  = '0;
    logic [3:0]  dpIn      = '0;
    logic        updateIn  = 1'b0;
    logic        blankLzIn = 1'b0;
    logic [6:0]  segOut;
    logic        dpOut;
    logic [3:0]  anodeOut;
    logic        frameOut;

    int nChecks    = 0;
    int nFails     = 0;
    int onehotViol = 0;

    // Reference model state: edges since reset release, pending shadow, snapshot at DRIVE entry.
    int          edges      = 0;
    logic [15:0] mDigits    = '0;
    logic [3:0]  mDp        = '0;
    logic [15:0] snapDigits = '0;
    logic [3:0]  snapDp     = '0;
    logic        snapLz     = 1'b0;

    seg7_scan_driver #(
        .CLK_HZ      (800),
        .FRAME_HZ    (10),
        .DIGITS      (4),
        .DEAD_CYCLES (2),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .clkIn     (clkIn),
        .resetIn   (resetIn),
        .digitsIn  (digitsIn),
        .dpIn      (dpIn),
        .updateIn  (updateIn),
        .blankLzIn (blankLzIn),
        .segOut    (segOut),
        .dpOut     (dpOut),
        .anodeOut  (anodeOut),
        .frameOut  (frameOut)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            edges      <= 0;
            mDigits    <= '0;
            mDp        <= '0;
            snapDigits <= '0;
            snapDp     <= '0;
            snapLz     <= 1'b0;
        end else begin
            edges <= edges + 1;
            if (updateIn) begin
                mDigits <= digitsIn;
                mDp     <= dpIn;
            end
            if ((edges + 1) % SLOT == DEAD) begin
                snapDigits <= mDigits;
                snapDp     <= mDp;
                snapLz     <= blankLzIn;
            end
        end
    end

    always @(negedge clkIn) begin
        if ($countones(~anodeOut) > 1) onehotViol <= onehotViol + 1;
    end

    function automatic logic [6:0] glyphOf(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected {anode, seg, dp, frame} from the position inside the frame.
    function automatic logic [12:0] expOut();
        int          pos;
        int          dig;
        int          ph;
        logic [3:0]  value;
        logic        blanked;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fr;
        pos = edges % FRAME;
        dig = pos / SLOT;
        ph  = pos % SLOT;
        fr  = (pos == 0) && (edges > 0);
        if (ph < DEAD) return {4'b1111, 7'h7F, 1'b1, fr};
        value   = 4'(snapDigits >> (4 * dig));
        blanked = snapLz && (dig > 0) && ((snapDigits >> (4 * dig)) == 16'd0);
        seg     = blanked ? 7'h7F : ~glyphOf(value);
        an      = ~(4'b0001 << dig);
        return {an, seg, ~snapDp[dig], fr};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clkIn);
        nChecks++;
        if ({anodeOut, segOut, dpOut, frameOut} !== RESET_OUT) begin
            nFails++;
            $display("FAIL reset_hold got=%h want=%h", {anodeOut, segOut, dpOut, frameOut}, RESET_OUT);
        end
        resetIn = 1'b1;
        #1;
        nChecks++;
        if ({anodeOut, segOut, dpOut, frameOut} !== expOut()) begin
            nFails++;
            $display("FAIL reset_release got=%h want=%h", {anodeOut, segOut, dpOut, frameOut}, expOut());
        end
    endtask

    task automatic test_idle_scan();
        int nFrames = 0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clkIn);
            nChecks++;
            if ({anodeOut, segOut, dpOut, frameOut} !== expOut()) begin
                nFails++;
                $display("FAIL idle_scan edge=%0d got=%h want=%h", edges,
                         {anodeOut, segOut, dpOut, frameOut}, expOut());
            end
            if (edges % FRAME >= DEAD && edges % FRAME < SLOT) begin
                nChecks++;
                if (anodeOut !== 4'b1110 || segOut !== 7'b1000000) begin
                    nFails++;
                    $display("FAIL idle_digit0 edge=%0d got=%b/%b want=1110/1000000", edges,
                             anodeOut, segOut);
                end
            end
            if (frameOut === 1'b1) begin
                nFrames++;
                nChecks++;
                if (edges % FRAME != 0) begin
                    nFails++;
                    $display("FAIL frame_pos edge=%0d want multiple of %0d", edges, FRAME);
                end
            end
        end
        nChecks++;
        if (nFrames != 2) begin
            nFails++;
            $display("FAIL frame_count got=%0d want=2", nFrames);
        end
    endtask

    task automatic test_digits();
        logic [6:0] want [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        @(negedge clkIn);
        digitsIn = 16'h1234; dpIn = 4'b0010; updateIn = 1'b1;
        @(negedge clkIn);
        updateIn = 1'b0;
        for (int i = 0; i < 180; i++) begin
            @(negedge clkIn);
            nChecks++;
            if ({anodeOut, segOut, dpOut, frameOut} !== expOut()) begin
                nFails++;
                $display("FAIL digits edge=%0d got=%h want=%h", edges,
                         {anodeOut, segOut, dpOut, frameOut}, expOut());
            end
            if (i >= 100 && edges % SLOT >= DEAD) begin
                int d = (edges % FRAME) / SLOT;
                nChecks++;
                if (segOut !== want[d] || dpOut !== (d != 1)) begin
                    nFails++;
                    $display("FAIL digits_glyph digit=%0d got=%h/%b want=%h/%b", d, segOut, dpOut,
                             want[d], (d != 1));
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2] = '{16'h0007, 16'h0000};
        logic [6:0]  d0   [2] = '{7'h78, 7'h40};
        dpIn = 4'b0000;
        blankLzIn = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clkIn);
            digitsIn = vals[t]; updateIn = 1'b1;
            @(negedge clkIn);
            updateIn = 1'b0;
            for (int i = 0; i < 180; i++) begin
                @(negedge clkIn);
                nChecks++;
                if ({anodeOut, segOut, dpOut, frameOut} !== expOut()) begin
                    nFails++;
                    $display("FAIL lz edge=%0d got=%h want=%h", edges,
                             {anodeOut, segOut, dpOut, frameOut}, expOut());
                end
                if (i >= 100 && edges % SLOT >= DEAD) begin
                    int d = (edges % FRAME) / SLOT;
                    logic [6:0] w = (d == 0) ? d0[t] : 7'h7F;
                    nChecks++;
                    if (segOut !== w || anodeOut !== 4'(~(4'b0001 << d))) begin
                        nFails++;
                        $display("FAIL lz_glyph case=%0d digit=%0d got=%h/%b want=%h", t, d,
                                 segOut, anodeOut, w);
                    end
                end
            end
        end
        blankLzIn = 1'b0;
    endtask

    task automatic test_update_at_drive_entry();
        bit found = 0;
        @(negedge clkIn);
        digitsIn = 16'hA987; updateIn = 1'b1;
        @(negedge clkIn);
        updateIn = 1'b0;
        repeat (FRAME) @(negedge clkIn);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clkIn);
            if (edges % FRAME == 41) found = 1;
        end
        nChecks++;
        if (!found) begin
            nFails++;
            $display("FAIL sync_update_wait got=timeout want=pos41");
        end
        digitsIn = 16'h1234; updateIn = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clkIn);
            updateIn = 1'b0;
            nChecks++;
            if (anodeOut !== 4'b1011 || segOut !== 7'h10) begin
                nFails++;
                $display("FAIL sync_update_old i=%0d got=%b/%h want=1011/10", i, anodeOut, segOut);
            end
        end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clkIn);
            if (edges % FRAME == 42) found = 1;
        end
        for (int i = 0; i < 18; i++) begin
            nChecks++;
            if (anodeOut !== 4'b1011 || segOut !== 7'h24) begin
                nFails++;
                $display("FAIL sync_update_new i=%0d got=%b/%h want=1011/24", i, anodeOut, segOut);
            end
            @(negedge clkIn);
        end
    endtask

    task automatic test_hex();
        logic [6:0] want [4] = '{7'h46, 7'h21, 7'h06, 7'h0E};
        @(negedge clkIn);
        digitsIn = 16'hFEDC; dpIn = 4'($urandom); updateIn = 1'b1;
        @(negedge clkIn);
        updateIn = 1'b0;
        for (int i = 0; i < 180; i++) begin
            @(negedge clkIn);
            nChecks++;
            if ({anodeOut, segOut, dpOut, frameOut} !== expOut()) begin
                nFails++;
                $display("FAIL hex edge=%0d got=%h want=%h", edges,
                         {anodeOut, segOut, dpOut, frameOut}, expOut());
            end
            if (i >= 100 && edges % SLOT >= DEAD) begin
                int d = (edges % FRAME) / SLOT;
                nChecks++;
                if (segOut !== want[d]) begin
                    nFails++;
                    $display("FAIL hex_glyph digit=%0d got=%h want=%h", d, segOut, want[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(60, 240);
            blankLzIn = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                @(negedge clkIn);
                nChecks++;
                if ({anodeOut, segOut, dpOut, frameOut} !== expOut()) begin
                    nFails++;
                    $display("FAIL random run=%0d edge=%0d got=%h want=%h", r, edges,
                             {anodeOut, segOut, dpOut, frameOut}, expOut());
                end
                digitsIn = 16'($urandom) >> (4 * $urandom_range(0, 3));
                dpIn     = 4'($urandom);
                updateIn = ($urandom_range(0, 15) == 0);
            end
        end
        @(negedge clkIn);
        updateIn  = 1'b0;
        blankLzIn = 1'b0;
    endtask

    task automatic test_reset_mid_drive();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clkIn);
            if (edges % FRAME == 50) found = 1;
        end
        #2 resetIn = 1'b0;
        #1;
        nChecks++;
        if ({anodeOut, segOut, dpOut, frameOut} !== RESET_OUT) begin
            nFails++;
            $display("FAIL reset_async got=%h want=%h", {anodeOut, segOut, dpOut, frameOut},
                     RESET_OUT);
        end
        @(negedge clkIn);
        resetIn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clkIn);
            nChecks++;
            if ({anodeOut, segOut, dpOut, frameOut} !== expOut()) begin
                nFails++;
                $display("FAIL reset_resume edge=%0d got=%h want=%h", edges,
                         {anodeOut, segOut, dpOut, frameOut}, expOut());
            end
            if (i < 19 && edges % SLOT >= DEAD) begin
                nChecks++;
                if (anodeOut !== 4'b1110 || segOut !== 7'h40 || dpOut !== 1'b1) begin
                    nFails++;
                    $display("FAIL reset_shadow got=%b/%h/%b want=1110/40/1", anodeOut, segOut,
                             dpOut);
                end
            end
        end
    endtask

    task automatic test_onehot();
        nChecks++;
        if (onehotViol != 0) begin
            nFails++;
            $display("FAIL anode_onehot violations=%0d want=0", onehotViol);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_digits();
        test_leading_zero();
        test_update_at_drive_entry();
        test_hex();
        test_random();
        test_reset_mid_drive();
        test_onehot();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
